if_fetch: RTL and testbench

- Instruction-fetch stage sitting directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM's `ce`/`addr`.
- Captures the ROM's combinational `inst` into the IF/ID pipeline register feeding decode.
- Handles pipeline stall, branch redirect (with one delay slot), exception flush, and misaligned-fetch detection.

---
 rtl/if_fetch_pkg.sv | 12 +
 rtl/if_fetch_if_id_reg.sv | 28 ++
 rtl/if_fetch.sv | 59 +++++
 tb/tb_if_fetch.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared fetch-stage constants, bus widths and fetch FSM states.
package if_fetch_pkg;
    localparam logic        RstEnable    = 1'b1;
    localparam logic        ChipEnable   = 1'b1;
    localparam logic        ChipDisable  = 1'b0;
    localparam int          InstAddrBus  = 32;
    localparam int          InstBus      = 32;
    localparam int          StallBus     = 6;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    typedef enum logic {IDLE, RUN} fetch_state_t;
endpackage

// File: rtl/if_fetch_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with flush, bubble insertion and hold.
module if_id_reg
    import if_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic [1:0]             i_stall,
    input  logic [InstAddrBus-1:0] i_pc,
    input  logic [InstBus-1:0]     i_inst,
    input  logic                   i_adel,
    output logic [InstAddrBus-1:0] o_id_pc,
    output logic [InstBus-1:0]     o_id_inst,
    output logic                   o_id_adel
);
    // i_stall[0] stalls IF, i_stall[1] stalls ID: IF stalled alone inserts a bubble
    always_ff @(posedge clk) begin
        if (rst == RstEnable || i_flush || (i_stall[0] && !i_stall[1])) begin
            o_id_pc   <= ZeroWord;
            o_id_inst <= ZeroWord;
            o_id_adel <= 1'b0;
        end else if (!i_stall[0]) begin
            o_id_pc   <= i_pc;
            o_id_inst <= i_inst;
            o_id_adel <= i_adel;
        end
    end
endmodule

// File: rtl/if_fetch.sv
// if_fetch: program counter, ROM enable FSM and misaligned-fetch detection.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = RESET_PC_DEF,
    parameter int                     STALL_W  = StallBus
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall,
    input  logic                   flush,
    input  logic [InstAddrBus-1:0] new_pc,
    input  logic                   branch_flag_i,
    input  logic [InstAddrBus-1:0] branch_target_address_i,
    input  logic [InstBus-1:0]     inst_i,
    output logic                   ce,
    output logic [InstAddrBus-1:0] pc,
    output logic [InstAddrBus-1:0] id_pc,
    output logic [InstBus-1:0]     id_inst,
    output logic                   id_excpt_adel
);
    fetch_state_t r_state;
    logic         w_adel;
    logic [31:0]  w_inst;
    logic         w_unused;

    assign w_adel   = (r_state == RUN) && (pc[1:0] != 2'b00);
    assign w_inst   = (r_state == RUN && !w_adel) ? inst_i : ZeroWord;
    assign w_unused = ^stall;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state <= IDLE;
            ce      <= ChipDisable;
            pc      <= RESET_PC;
        end else if (r_state == IDLE) begin
            r_state <= RUN;
            ce      <= ChipEnable;
        end else begin
            pc <= flush         ? new_pc :
                  stall[0]      ? pc :
                  branch_flag_i ? branch_target_address_i :
                                  pc + 32'd4;
        end
    end

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (flush),
        .i_stall   (stall[2:1]),
        .i_pc      (pc),
        .i_inst    (w_inst),
        .i_adel    (w_adel),
        .o_id_pc   (id_pc),
        .o_id_inst (id_inst),
        .o_id_adel (id_excpt_adel)
    );
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed test of if_fetch against a ROM returning ~addr.
module tb_if_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic [31:0] inst_i;
    logic        ce;
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_excpt_adel;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    assign inst_i = ~pc;

    if_fetch dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .inst_i                  (inst_i),
        .ce                      (ce),
        .pc                      (pc),
        .id_pc                   (id_pc),
        .id_inst                 (id_inst),
        .id_excpt_adel           (id_excpt_adel)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_id(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst, input logic e_adel);
        check({tag, "_idpc"}, id_pc, e_pc);
        check({tag, "_idinst"}, id_inst, e_inst);
        check({tag, "_adel"}, {31'b0, id_excpt_adel}, {31'b0, e_adel});
    endtask

    initial begin
        rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0;
        branch_flag_i = 1'b0; branch_target_address_i = '0;
        repeat (3) tick();
        check("rst_ce", {31'b0, ce}, 32'd0);
        check("rst_pc", pc, 32'h0);
        chk_id("rst", 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        tick();
        check("rel_ce", {31'b0, ce}, 32'd1);
        check("rel_pc", pc, 32'h0);
        chk_id("idle", 32'h0, 32'h0, 1'b0);
        tick();
        check("pc4", pc, 32'h4);
        chk_id("f0", 32'h0, ~32'h0, 1'b0);
        tick();
        check("pc8", pc, 32'h8);
        chk_id("f4", 32'h4, ~32'h4, 1'b0);
        repeat (2) tick();
        check("pc10", pc, 32'h10);
        chk_id("fc", 32'hC, ~32'hC, 1'b0);
        stall = 6'b000011;
        tick();
        check("st1_pc", pc, 32'h10);
        chk_id("bub1", 32'h0, 32'h0, 1'b0);
        tick();
        check("st2_pc", pc, 32'h10);
        chk_id("bub2", 32'h0, 32'h0, 1'b0);
        stall = 6'b000111;
        tick();
        check("st3_pc", pc, 32'h10);
        chk_id("hold0", 32'h0, 32'h0, 1'b0);
        stall = '0;
        tick();
        check("rel_pc14", pc, 32'h14);
        chk_id("f10", 32'h10, ~32'h10, 1'b0);
        stall = 6'b000111;
        tick();
        check("hold_pc", pc, 32'h14);
        chk_id("hold", 32'h10, ~32'h10, 1'b0);
        stall = '0;
        repeat (3) tick();
        check("pc20", pc, 32'h20);
        chk_id("f1c", 32'h1C, ~32'h1C, 1'b0);
        branch_flag_i = 1'b1; branch_target_address_i = 32'h100;
        tick();
        branch_flag_i = 1'b0;
        check("br_pc", pc, 32'h100);
        chk_id("dslot", 32'h20, ~32'h20, 1'b0);
        tick();
        check("br_pc104", pc, 32'h104);
        chk_id("f100", 32'h100, ~32'h100, 1'b0);
        stall = 6'b000001; branch_flag_i = 1'b1; branch_target_address_i = 32'h300;
        tick();
        stall = '0; branch_flag_i = 1'b0;
        check("stbr_pc", pc, 32'h104);
        chk_id("stbr", 32'h104, ~32'h104, 1'b0);
        tick();
        check("stbr_pc108", pc, 32'h108);
        flush = 1'b1; new_pc = 32'h180; branch_flag_i = 1'b1; branch_target_address_i = 32'h200;
        tick();
        flush = 1'b0; branch_flag_i = 1'b0;
        check("fl_pc", pc, 32'h180);
        chk_id("fl", 32'h0, 32'h0, 1'b0);
        tick();
        check("fl_pc184", pc, 32'h184);
        chk_id("f180", 32'h180, ~32'h180, 1'b0);
        branch_flag_i = 1'b1; branch_target_address_i = 32'h102;
        tick();
        branch_flag_i = 1'b0;
        check("mis_pc", pc, 32'h102);
        tick();
        check("mis_pc106", pc, 32'h106);
        chk_id("mis102", 32'h102, 32'h0, 1'b1);
        tick();
        check("mis_pc10a", pc, 32'h10A);
        chk_id("mis106", 32'h106, 32'h0, 1'b1);
        flush = 1'b1; new_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        check("wr_pc", pc, 32'hFFFF_FFFC);
        chk_id("wrfl", 32'h0, 32'h0, 1'b0);
        tick();
        check("wrap_pc", pc, 32'h0);
        chk_id("ffc", 32'hFFFF_FFFC, 32'h3, 1'b0);
        tick();
        check("wrap_pc4", pc, 32'h4);
        rst = 1'b1;
        tick();
        check("mrst_ce", {31'b0, ce}, 32'd0);
        check("mrst_pc", pc, 32'h0);
        chk_id("mrst", 32'h0, 32'h0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
